// File: rtl/cavlc_bitstream_packer.sv
// CAVLC bitstream packer: concatenates variable-length MSB-first code chunks
// into a continuous bitstream and emits fixed-width words. A flush closes the
// stream with one zero-padded final word that reports its valid byte count.
module cavlc_bitstream_packer #(
    parameter int CODE_W = 128,
    parameter int BIT_W  = 7,
    parameter int OUT_W  = 32,
    parameter int ACC_W  = CODE_W + OUT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              h264_reset,
    input  logic              cavlc_enc_valid,
    input  logic [CODE_W-1:0] cavlc_bitstream_code,
    input  logic [BIT_W-1:0]  cavlc_bitstream_bit,
    output logic              packer_ready,
    input  logic              flush_req,
    output logic [OUT_W-1:0]  word_o,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              word_last,
    output logic [2:0]        word_bytes,
    output logic              flush_done
);

    localparam logic [7:0] OUT_W_F    = 8'(OUT_W);
    localparam logic [7:0] ACC_W_F    = 8'(ACC_W);
    localparam logic [2:0] FULL_BYTES = 3'(OUT_W / 8);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_LAST = 1'b1
    } state_t;

    // Number of bytes needed to hold f bits (f is below OUT_W in LAST).
    function automatic logic [2:0] ceil_bytes(input logic [7:0] f);
        logic [7:0] t;
        t = f + 8'd7;
        return t[5:3];
    endfunction

    state_t            state_r;
    state_t            state_n;
    logic [7:0]        fill_r;
    logic [7:0]        fill_n;
    logic [ACC_W-1:0]  acc_r;
    logic [ACC_W-1:0]  acc_n;
    logic              flush_pending_r;
    logic              flush_pending_n;
    logic              flush_done_r;
    logic              flush_done_n;

    logic              clear_s;
    logic              accept_s;
    logic              emit_s;
    logic [7:0]        n_s;
    logic [CODE_W-1:0] one_s;
    logic [CODE_W-1:0] mask_s;
    logic [ACC_W-1:0]  code_ext_s;
    logic [ACC_W-1:0]  base_acc_s;
    logic [7:0]        base_fill_s;
    logic [7:0]        shamt_s;
    logic [ACC_W-1:0]  appended_s;

    // Output decode from the registered state; bits beyond fill are always zero,
    // so the top slice is already the zero-padded final word in LAST.
    always_comb begin
        clear_s      = !rst || h264_reset;
        packer_ready = !clear_s && (state_r == ST_RUN) && !flush_pending_r
                       && (fill_r <= OUT_W_F);
        word_valid   = (state_r == ST_LAST) || (fill_r >= OUT_W_F);
        word_o       = acc_r[ACC_W-1 -: OUT_W];
        word_last    = (state_r == ST_LAST);
        if (state_r == ST_LAST) begin
            word_bytes = ceil_bytes(fill_r);
        end else begin
            word_bytes = FULL_BYTES;
        end
        flush_done   = flush_done_r;
    end

    // Datapath helpers: mask the chunk to its n LSBs and place it directly
    // behind the valid bits that remain after an optional word shift.
    always_comb begin
        accept_s   = cavlc_enc_valid && packer_ready;
        emit_s     = word_valid && word_ready;
        n_s        = {{(8-BIT_W){1'b0}}, cavlc_bitstream_bit};
        one_s      = {{(CODE_W-1){1'b0}}, 1'b1};
        mask_s     = (one_s << n_s) - one_s;
        code_ext_s = {{OUT_W{1'b0}}, cavlc_bitstream_code & mask_s};
        if (emit_s && (state_r == ST_RUN)) begin
            base_acc_s  = acc_r << OUT_W;
            base_fill_s = fill_r - OUT_W_F;
        end else begin
            base_acc_s  = acc_r;
            base_fill_s = fill_r;
        end
        shamt_s    = ACC_W_F - base_fill_s - n_s;
        appended_s = code_ext_s << shamt_s;
    end

    // Next-state logic: word draining, chunk append and flush sequencing.
    always_comb begin
        state_n         = state_r;
        fill_n          = fill_r;
        acc_n           = acc_r;
        flush_pending_n = flush_pending_r;
        flush_done_n    = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (accept_s) begin
                    acc_n  = base_acc_s | appended_s;
                    fill_n = base_fill_s + n_s;
                end else begin
                    acc_n  = base_acc_s;
                    fill_n = base_fill_s;
                end
                if (flush_pending_r) begin
                    if (fill_r < OUT_W_F) begin
                        if (fill_r != 8'd0) begin
                            state_n = ST_LAST;
                        end else begin
                            flush_pending_n = 1'b0;
                            flush_done_n    = 1'b1;
                        end
                    end else begin
                        flush_pending_n = 1'b1;
                    end
                end else if (flush_req) begin
                    flush_pending_n = 1'b1;
                end else begin
                    flush_pending_n = 1'b0;
                end
            end
            ST_LAST: begin
                if (emit_s) begin
                    acc_n           = '0;
                    fill_n          = 8'd0;
                    flush_pending_n = 1'b0;
                    flush_done_n    = 1'b1;
                    state_n         = ST_RUN;
                end else begin
                    state_n = ST_LAST;
                end
            end
            default: begin
                state_n         = ST_RUN;
                acc_n           = '0;
                fill_n          = 8'd0;
                flush_pending_n = 1'b0;
            end
        endcase
    end

    // State register with synchronous hard reset and soft clear.
    always_ff @(posedge clk) begin
        if (!rst || h264_reset) begin
            state_r         <= ST_RUN;
            fill_r          <= 8'd0;
            acc_r           <= '0;
            flush_pending_r <= 1'b0;
            flush_done_r    <= 1'b0;
        end else begin
            state_r         <= state_n;
            fill_r          <= fill_n;
            acc_r           <= acc_n;
            flush_pending_r <= flush_pending_n;
            flush_done_r    <= flush_done_n;
        end
    end

endmodule

// File: tb/tb_cavlc_bitstream_packer.sv
// Scoreboard bench for cavlc_bitstream_packer: accepted chunks are pushed as
// individual bits into an expected-bit queue; an observer pops whole words
// (or the padded final word) on every output handshake and compares.
module tb_cavlc_bitstream_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic         h264_reset;
    logic         cavlc_enc_valid;
    logic [127:0] cavlc_bitstream_code;
    logic [6:0]   cavlc_bitstream_bit;
    logic         packer_ready;
    logic         flush_req;
    logic [31:0]  word_o;
    logic         word_valid;
    logic         word_ready;
    logic         word_last;
    logic [2:0]   word_bytes;
    logic         flush_done;

    cavlc_bitstream_packer dut (
        .clk                  (clk),
        .rst                  (rst),
        .h264_reset           (h264_reset),
        .cavlc_enc_valid      (cavlc_enc_valid),
        .cavlc_bitstream_code (cavlc_bitstream_code),
        .cavlc_bitstream_bit  (cavlc_bitstream_bit),
        .packer_ready         (packer_ready),
        .flush_req            (flush_req),
        .word_o               (word_o),
        .word_valid           (word_valid),
        .word_ready           (word_ready),
        .word_last            (word_last),
        .word_bytes           (word_bytes),
        .flush_done           (flush_done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;
    bit          q[$];
    bit          pend = 1'b0;
    bit          in_last = 1'b0;
    bit          exp_done = 1'b0;
    bit          hold_valid = 1'b0;
    logic [31:0] hold_word;
    bit          prev_rst = 1'b1;
    bit          rand_ready = 1'b0;
    bit          ready_force = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Downstream ready: forced level or random backpressure.
    always @(posedge clk) begin
        #2;
        word_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    // Observer: reference bitstream model and output comparison.
    always @(negedge clk) begin
        int          sz0;
        bit          p0;
        bit          l0;
        bit          ev;
        bit          er;
        logic [31:0] ew;
        if (!rst || h264_reset) begin
            chk("ready_in_reset", packer_ready, 0);
            if (prev_rst) begin
                chk("rst_word_valid", word_valid, 0);
                chk("rst_word_o", word_o, 0);
                chk("rst_word_bytes", word_bytes, 4);
                chk("rst_flush_done", flush_done, 0);
                chk("rst_word_last", word_last, 0);
            end
            q.delete();
            pend = 0; in_last = 0; exp_done = 0; hold_valid = 0; prev_rst = 1;
        end else begin
            prev_rst = 0;
            sz0 = q.size(); p0 = pend; l0 = in_last;
            ev = l0 || (sz0 >= 32);
            er = !p0 && !l0 && (sz0 <= 32);
            chk("flush_done", flush_done, exp_done);
            exp_done = 0;
            chk("word_valid", word_valid, ev);
            chk("packer_ready", packer_ready, er);
            if (hold_valid && ev) chk("word_hold", word_o, hold_word);
            if (ev && word_ready) begin
                ew = '0;
                if (l0) begin
                    for (int i = 0; i < sz0; i++) ew[31-i] = q.pop_front();
                    chk("last_word", word_o, ew);
                    chk("last_flag", word_last, 1);
                    chk("last_bytes", word_bytes, (sz0 + 7) / 8);
                    in_last = 0; pend = 0; exp_done = 1;
                end else begin
                    for (int i = 0; i < 32; i++) ew[31-i] = q.pop_front();
                    chk("word", word_o, ew);
                    chk("word_last0", word_last, 0);
                    chk("word_bytes4", word_bytes, 4);
                end
                hold_valid = 0;
            end else if (ev) begin
                hold_valid = 1;
                hold_word  = word_o;
            end else begin
                hold_valid = 0;
            end
            if (cavlc_enc_valid && er) begin
                for (int i = int'(cavlc_bitstream_bit) - 1; i >= 0; i--)
                    q.push_back(cavlc_bitstream_code[i]);
            end
            if (p0 && !l0 && sz0 < 32) begin
                if (sz0 > 0) in_last = 1;
                else begin pend = 0; exp_done = 1; end
            end else if (!p0 && flush_req) begin
                pend = 1;
            end
        end
    end

    // Present a chunk and hold it until accepted.
    task automatic send(input logic [127:0] c, input int n);
        int t = 0;
        cavlc_enc_valid = 1'b1; cavlc_bitstream_code = c; cavlc_bitstream_bit = 7'(n);
        @(negedge clk);
        while (!packer_ready && t < 300) begin t++; @(negedge clk); end
        chk("send_accepted", packer_ready, 1);
        @(posedge clk); #1;
        cavlc_enc_valid = 1'b0;
    endtask

    // Chunk with flush_req in the very cycle it is accepted.
    task automatic send_fl(input logic [127:0] c, input int n);
        int t = 0;
        while (!packer_ready && t < 300) begin @(posedge clk); #1; t++; end
        chk("sendfl_ready", packer_ready, 1);
        cavlc_enc_valid = 1'b1; flush_req = 1'b1;
        cavlc_bitstream_code = c; cavlc_bitstream_bit = 7'(n);
        @(posedge clk); #1;
        cavlc_enc_valid = 1'b0; flush_req = 1'b0;
    endtask

    task automatic flush();
        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((q.size() != 0 || pend || exp_done) && t < 3000) begin @(posedge clk); #1; t++; end
        checks++;
        if (t < 3000) passes++;
        else $display("FAIL idle_timeout: %0d bits still queued, pending %0d", q.size(), pend);
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        rst = 1'b0; h264_reset = 1'b0; cavlc_enc_valid = 1'b0; flush_req = 1'b0;
        cavlc_bitstream_code = '0; cavlc_bitstream_bit = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // 101 followed by 29 ones
        send(128'h5, 3);
        send(128'h1FFF_FFFF, 29);
        wait_idle();

        // 127 ones: three full words and a 31-bit tail
        send({1'b0, {127{1'b1}}}, 127);
        flush();
        wait_idle();

        // Short tail, then a flush with nothing buffered
        send(128'h3, 2);
        flush();
        wait_idle();
        flush();
        wait_idle();

        // Backpressure while feeding 40 chunks of 20 bits
        ready_force = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) send(rnd128(), 20);
            end
            begin
                repeat (30) @(posedge clk);
                #1 ready_force = 1'b1;
            end
        join
        flush();
        wait_idle();

        // Soft clear with 50 bits buffered and a word waiting
        ready_force = 1'b0;
        send(rnd128(), 30);
        send(rnd128(), 20);
        h264_reset = 1'b1;
        @(posedge clk); #1;
        h264_reset = 1'b0;
        ready_force = 1'b1;
        send(128'hA, 4);
        flush();
        wait_idle();

        // Random chunks, random backpressure, random flushes
        rand_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) send_fl(rnd128(), $urandom_range(0, 127));
            else send(rnd128(), $urandom_range(0, 127));
            if (r == 1) flush();
        end
        rand_ready = 1'b0;
        ready_force = 1'b1;
        flush();
        wait_idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
